// File: rtl/bcd_counter_display.sv
// N-digit BCD up/down counter with debounced clear and a multiplexed 7-segment scan.
// Optional macro BCD_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).

module bcd_digit (
    input  logic [3:0] d_i,
    input  logic       en_i,
    input  logic       up_i,
    output logic [3:0] q_o,
    output logic       carry_o
);
    always_comb begin
        q_o     = d_i;
        carry_o = 1'b0;
        if (en_i) begin
            if (up_i) begin
                if (d_i == 4'd9) begin
                    q_o     = 4'd0;
                    carry_o = 1'b1;
                end else begin
                    q_o = d_i + 4'd1;
                end
            end else begin
                if (d_i == 4'd0) begin
                    q_o     = 4'd9;
                    carry_o = 1'b1;
                end else begin
                    q_o = d_i - 4'd1;
                end
            end
        end
    end
endmodule

module bcd_counter_display #(
    parameter int NUM_DIGITS      = 4,
    parameter int CLK_HZ          = 50000000,
    parameter int COUNT_HZ        = 10,
    parameter int REFRESH_HZ      = 1000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    switch,
    input  logic                    button,
    output logic [4*NUM_DIGITS-1:0] count_bcd,
    output logic                    wrap,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [7:0]              cathode
);
    localparam int COUNT_DIV   = CLK_HZ / COUNT_HZ;
    localparam int REFRESH_DIV = CLK_HZ / REFRESH_HZ;
    localparam int CNT_W       = $clog2(COUNT_DIV);
    localparam int REF_W       = $clog2(REFRESH_DIV);
    localparam int DB_W        = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    logic                         sw_s1_q, sw_s2_q, btn_s1_q, btn_s2_q;
    logic                         btn_db_q, btn_db_d;
    logic [DB_W-1:0]              db_cnt_q, db_cnt_d;
    logic [CNT_W-1:0]             cnt_pre_q, cnt_pre_d;
    logic [REF_W-1:0]             ref_pre_q, ref_pre_d;
    logic [IDX_W-1:0]             scan_idx_q, scan_idx_d;
    logic [NUM_DIGITS-1:0][3:0]   count_q, count_d, dig_nxt;
    logic [NUM_DIGITS:0]          carry;
    logic                         wrap_q, wrap_d;
    logic [NUM_DIGITS-1:0]        anode_q, anode_d, blank;
    logic [7:0]                   cathode_q, cathode_d;
    logic                         cnt_tick, ref_tick;

    assign cnt_tick = (cnt_pre_q == CNT_W'(COUNT_DIV - 1));
    assign ref_tick = (ref_pre_q == REF_W'(REFRESH_DIV - 1));
    assign cnt_pre_d = cnt_tick ? '0 : cnt_pre_q + CNT_W'(1);
    assign ref_pre_d = ref_tick ? '0 : ref_pre_q + REF_W'(1);

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        btn_db_d = btn_db_q;
        db_cnt_d = '0;
        if (btn_s2_q != btn_db_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_db_d = btn_s2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    // Ripple carry/borrow chain; the tick enters digit 0 and the last carry is the rollover.
    assign carry[0] = cnt_tick;
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        bcd_digit u_digit (
            .d_i     (count_q[k]),
            .en_i    (carry[k]),
            .up_i    (sw_s2_q),
            .q_o     (dig_nxt[k]),
            .carry_o (carry[k+1])
        );
    end

    always_comb begin
        count_d = dig_nxt;
        wrap_d  = carry[NUM_DIGITS];
        if (btn_db_q) begin
            count_d = '0;
            wrap_d  = 1'b0;
        end
    end

`ifdef BCD_LEADING_ZERO_BLANK_EN
    always_comb begin
        logic zero_above;
        blank      = '0;
        zero_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            zero_above = zero_above && (count_q[k] == 4'd0);
            blank[k]   = zero_above;
        end
    end
`else
    assign blank = '0;
`endif

    always_comb begin
        scan_idx_d = scan_idx_q;
        if (ref_tick) begin
            scan_idx_d = (scan_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + IDX_W'(1);
        end
        anode_d   = ~(NUM_DIGITS'(1) << scan_idx_q);
        cathode_d = blank[scan_idx_q] ? 8'hFF : seg7(count_q[scan_idx_q]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_s1_q    <= 1'b0;
            sw_s2_q    <= 1'b0;
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
            btn_db_q   <= 1'b0;
            db_cnt_q   <= '0;
            cnt_pre_q  <= '0;
            ref_pre_q  <= '0;
            scan_idx_q <= '0;
            count_q    <= '0;
            wrap_q     <= 1'b0;
            anode_q    <= ~NUM_DIGITS'(1);
            cathode_q  <= 8'hC0;
        end else begin
            sw_s1_q    <= switch;
            sw_s2_q    <= sw_s1_q;
            btn_s1_q   <= button;
            btn_s2_q   <= btn_s1_q;
            btn_db_q   <= btn_db_d;
            db_cnt_q   <= db_cnt_d;
            cnt_pre_q  <= cnt_pre_d;
            ref_pre_q  <= ref_pre_d;
            scan_idx_q <= scan_idx_d;
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            anode_q    <= anode_d;
            cathode_q  <= cathode_d;
        end
    end

    assign count_bcd = count_q;
    assign wrap      = wrap_q;
    assign anode     = anode_q;
    assign cathode   = cathode_q;
endmodule

// File: tb/tb_bcd_counter_display.sv
// Directed bench for bcd_counter_display: 4 digits, count divider 4, refresh divider 2, debounce 3.
// Edge numbers "e" below count rising edges after the last edge with reset high.

module tb_bcd_counter_display;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        switch = 1'b1;
    logic        button = 1'b0;
    logic [15:0] count_bcd;
    logic        wrap;
    logic [3:0]  anode;
    logic [7:0]  cathode;

    int n_checks = 0;
    int n_pass   = 0;

    bcd_counter_display #(
        .NUM_DIGITS(4), .CLK_HZ(1000), .COUNT_HZ(250), .REFRESH_HZ(500), .DEBOUNCE_CYCLES(3)
    ) dut (
        .clk(clk), .reset(reset), .switch(switch), .button(button),
        .count_bcd(count_bcd), .wrap(wrap), .anode(anode), .cathode(cathode)
    );

    always #5 clk = ~clk;

`ifdef BCD_LEADING_ZERO_BLANK_EN
    localparam logic [7:0] LZ = 8'hFF;
`else
    localparam logic [7:0] LZ = 8'hC0;
`endif

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        switch = 1'b1; button = 1'b0;
        do_reset();
        n_checks++; if (count_bcd !== 16'h0000) $display("FAIL rst_count got %h exp 0000", count_bcd); else n_pass++;
        n_checks++; if (wrap !== 1'b0) $display("FAIL rst_wrap got %b exp 0", wrap); else n_pass++;
        n_checks++; if (anode !== 4'b1110) $display("FAIL rst_anode got %b exp 1110", anode); else n_pass++;
        n_checks++; if (cathode !== 8'hC0) $display("FAIL rst_cathode got %h exp C0", cathode); else n_pass++;
        step(3); // e=3: no tick yet; scan shows digit 1 (a leading zero)
        n_checks++; if (count_bcd !== 16'h0000) $display("FAIL cnt_e3 got %h exp 0000", count_bcd); else n_pass++;
        n_checks++; if (anode !== 4'b1101) $display("FAIL scan_e3_anode got %b exp 1101", anode); else n_pass++;
        n_checks++; if (cathode !== LZ) $display("FAIL scan_e3_cathode got %h exp %h", cathode, LZ); else n_pass++;
    endtask

    task automatic test_count_up();
        step(1); // e=4
        n_checks++; if (count_bcd !== 16'h0001) $display("FAIL up_first got %h exp 0001", count_bcd); else n_pass++;
        step(4); // e=8
        n_checks++; if (count_bcd !== 16'h0002) $display("FAIL up_second got %h exp 0002", count_bcd); else n_pass++;
        step(32); // e=40: ten ticks, digit 0 carried into digit 1
        n_checks++; if (count_bcd !== 16'h0010) $display("FAIL up_carry got %h exp 0010", count_bcd); else n_pass++;
    endtask

    task automatic test_wrap();
        switch = 1'b0;
        do_reset();
        step(3); // e=3
        n_checks++; if (wrap !== 1'b0) $display("FAIL wrap_pre got %b exp 0", wrap); else n_pass++;
        step(1); // e=4: 0000 down -> 9999
        n_checks++; if (count_bcd !== 16'h9999) $display("FAIL down_wrap_cnt got %h exp 9999", count_bcd); else n_pass++;
        n_checks++; if (wrap !== 1'b1) $display("FAIL down_wrap_pulse got %b exp 1", wrap); else n_pass++;
        step(1); // e=5
        n_checks++; if (wrap !== 1'b0) $display("FAIL down_wrap_len got %b exp 0", wrap); else n_pass++;
        switch = 1'b1;
        step(3); // e=8: direction synchronised by e=7, up tick 9999 -> 0000
        n_checks++; if (count_bcd !== 16'h0000) $display("FAIL up_wrap_cnt got %h exp 0000", count_bcd); else n_pass++;
        n_checks++; if (wrap !== 1'b1) $display("FAIL up_wrap_pulse got %b exp 1", wrap); else n_pass++;
        step(1); // e=9
        n_checks++; if (wrap !== 1'b0) $display("FAIL up_wrap_len got %b exp 0", wrap); else n_pass++;
        switch = 1'b0;
        step(3); // e=12
        n_checks++; if (count_bcd !== 16'h9999) $display("FAIL dir_change_cnt got %h exp 9999", count_bcd); else n_pass++;
        n_checks++; if (wrap !== 1'b1) $display("FAIL dir_change_wrap got %b exp 1", wrap); else n_pass++;
        step(1); // e=13
        n_checks++; if (wrap !== 1'b0) $display("FAIL dir_change_len got %b exp 0", wrap); else n_pass++;
    endtask

    task automatic test_clear();
        switch = 1'b1; button = 1'b0;
        do_reset();
        step(20); // e=20, count 5
        button = 1'b1;
        step(2);  // e=22: two-cycle glitch ends
        button = 1'b0;
        step(8);  // e=30
        n_checks++; if (count_bcd !== 16'h0007) $display("FAIL glitch_ignored got %h exp 0007", count_bcd); else n_pass++;
        button = 1'b1;
        step(5);  // e=35: debounced level flips at this edge, count not yet cleared
        n_checks++; if (count_bcd !== 16'h0008) $display("FAIL clear_not_yet got %h exp 0008", count_bcd); else n_pass++;
        step(1);  // e=36: cleared, coinciding with a tick
        n_checks++; if (count_bcd !== 16'h0000) $display("FAIL clear_applied got %h exp 0000", count_bcd); else n_pass++;
        n_checks++; if (wrap !== 1'b0) $display("FAIL clear_wrap got %b exp 0", wrap); else n_pass++;
        step(4);  // e=40: another tick while clear held
        n_checks++; if (count_bcd !== 16'h0000) $display("FAIL clear_held got %h exp 0000", count_bcd); else n_pass++;
        n_checks++; if (wrap !== 1'b0) $display("FAIL clear_held_wrap got %b exp 0", wrap); else n_pass++;
        step(2);  // e=42
        button = 1'b0;
        step(5);  // e=47: released level accepted at this edge
        n_checks++; if (count_bcd !== 16'h0000) $display("FAIL release_hold got %h exp 0000", count_bcd); else n_pass++;
        step(1);  // e=48: counting resumes
        n_checks++; if (count_bcd !== 16'h0001) $display("FAIL release_resume got %h exp 0001", count_bcd); else n_pass++;
    endtask

    task automatic test_scan();
        logic [3:0] exp_an [8];
        logic [7:0] exp_ca [8];
        // Window e=1225..1232: digit 0/1 show count 0x0306, digit 2/3 show 0x0307.
        exp_an = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111};
        exp_ca = '{8'h82, 8'h82, 8'hC0, 8'hC0, 8'hB0, 8'hB0, LZ, LZ};
        switch = 1'b1; button = 1'b0;
        do_reset();
        step(1220);
        n_checks++; if (count_bcd !== 16'h0305) $display("FAIL scan_count got %h exp 0305", count_bcd); else n_pass++;
        step(4);
        for (int i = 0; i < 8; i++) begin
            step(1);
            n_checks++; if (anode !== exp_an[i]) $display("FAIL scan_anode[%0d] got %b exp %b", i, anode, exp_an[i]); else n_pass++;
            n_checks++; if (cathode !== exp_ca[i]) $display("FAIL scan_cathode[%0d] got %h exp %h", i, cathode, exp_ca[i]); else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        switch = 1'b1; button = 1'b0;
        do_reset();
        step(169); // count 0x0042 reached at e=168
        n_checks++; if (count_bcd !== 16'h0042) $display("FAIL midrst_pre got %h exp 0042", count_bcd); else n_pass++;
        reset = 1'b1;
        step(1);
        n_checks++; if (count_bcd !== 16'h0000) $display("FAIL midrst_count got %h exp 0000", count_bcd); else n_pass++;
        n_checks++; if (anode !== 4'b1110) $display("FAIL midrst_anode got %b exp 1110", anode); else n_pass++;
        n_checks++; if (wrap !== 1'b0) $display("FAIL midrst_wrap got %b exp 0", wrap); else n_pass++;
        reset = 1'b0;
        step(3);
        n_checks++; if (count_bcd !== 16'h0000) $display("FAIL midrst_e3 got %h exp 0000", count_bcd); else n_pass++;
        step(1);
        n_checks++; if (count_bcd !== 16'h0001) $display("FAIL midrst_e4 got %h exp 0001", count_bcd); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap();
        test_clear();
        test_scan();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
